mdu_sequencer: RTL and testbench

- Multi-cycle controller that executes unsigned multiply (MULTU) and unsigned divide (DIVU) using the existing shared 32-bit ALU.
- Iterates the ALU once per cycle, 32 iterations per operation, and collects the 64-bit result in HI/LO registers.
- Sits beside the main datapath ALU. The main control unit starts it and stalls on Busy.

---
 rtl/mdu_sequencer_if.sv | 33 +++
 rtl/mdu_sequencer.sv | 139 +++++++++++++
 tb/tb_mdu_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_sequencer_if.sv
// Handshake and ALU-control bundle between the main control unit, the shared ALU
// and the multiply/divide sequencer.
interface mdu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Op;
  logic [WIDTH-1:0] Src_A;
  logic [WIDTH-1:0] Src_B;
  logic             Busy;
  logic             Done;
  logic             Div_By_Zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;
  logic             ALU_A_invert;
  logic             ALU_B_negate;
  logic [1:0]       ALU_Operation;
  logic [WIDTH-1:0] ALU_Result;

  modport slave (
    input  Start, Op, Src_A, Src_B, ALU_Result,
    output Busy, Done, Div_By_Zero, HI, LO,
    output ALU_A, ALU_B, ALU_A_invert, ALU_B_negate, ALU_Operation
  );

  modport master (
    output Start, Op, Src_A, Src_B, ALU_Result,
    input  Busy, Done, Div_By_Zero, HI, LO,
    input  ALU_A, ALU_B, ALU_A_invert, ALU_B_negate, ALU_Operation
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Shift-add MULTU / restoring DIVU sequencer that borrows the shared datapath ALU
// for one add or subtract per cycle, WIDTH iterations per operation.
module mdu_sequencer #(
  parameter int WIDTH = 32
) (
  input logic          Clk,
  input logic          Reset_n,
  mdu_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] alu_a_s;
  logic [WIDTH-1:0] alu_b_s;
  logic             alu_b_negate_s;
  logic [1:0]       alu_operation_s;
  logic [WIDTH-1:0] shifted_s;
  logic             carry_s;
  logic             borrow_s;

  // State and datapath registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state, iteration datapath and ALU control
  always_comb begin
    state_d         = state_q;
    hi_d            = hi_q;
    lo_d            = lo_q;
    m_d             = m_q;
    op_d            = op_q;
    cnt_d           = cnt_q;
    dbz_d           = dbz_q;
    alu_a_s         = '0;
    alu_b_s         = '0;
    alu_b_negate_s  = 1'b0;
    alu_operation_s = 2'b00;
    shifted_s       = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    carry_s         = 1'b0;
    borrow_s        = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.Start) begin
          op_d  = bus.Op;
          m_d   = bus.Src_B;
          cnt_d = '0;
          if (bus.Op && (bus.Src_B == '0)) begin
            hi_d    = bus.Src_A;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            hi_d    = '0;
            lo_d    = bus.Src_A;
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_CALC: begin
        alu_operation_s = 2'b10;
        if (!op_q) begin
          alu_a_s        = hi_q;
          alu_b_s        = lo_q[0] ? m_q : '0;
          carry_s        = (bus.ALU_Result < hi_q);
          {hi_d, lo_d}   = {carry_s, bus.ALU_Result, lo_q[WIDTH-1:1]};
        end else begin
          alu_a_s        = shifted_s;
          alu_b_s        = m_q;
          alu_b_negate_s = 1'b1;
          borrow_s       = (shifted_s < m_q);
          // HI[MSB] set means the shifted partial remainder overflowed WIDTH bits,
          // so it is certainly >= M even though the WIDTH-bit compare says borrow.
          if (hi_q[WIDTH-1] | ~borrow_s) begin
            hi_d = bus.ALU_Result;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = shifted_s;
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.Busy          = (state_q == S_CALC);
  assign bus.Done          = (state_q == S_DONE);
  assign bus.Div_By_Zero   = dbz_q;
  assign bus.HI            = hi_q;
  assign bus.LO            = lo_q;
  assign bus.ALU_A         = alu_a_s;
  assign bus.ALU_B         = alu_b_s;
  assign bus.ALU_A_invert  = 1'b0;
  assign bus.ALU_B_negate  = alu_b_negate_s;
  assign bus.ALU_Operation = alu_operation_s;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed MULTU/DIVU vectors, latency,
// ignored Start, back-to-back Start and mid-operation reset.
module tb_mdu_sequencer;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  mdu_sequencer_if #(.WIDTH(WIDTH)) m ();

  mdu_sequencer #(.WIDTH(WIDTH)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (m.slave)
  );

  // Reference ALU: ADD, or A - B when B_negate is set
  assign m.ALU_Result = (m.ALU_Operation == 2'b10)
                        ? (m.ALU_B_negate ? (m.ALU_A - m.ALU_B) : (m.ALU_A + m.ALU_B))
                        : '0;

  always #5 Clk = ~Clk;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse is matched against the oldest expected result
  always @(negedge Clk) begin
    if (m.Done === 1'b1) begin
      exp_t e;
      done_seen++;
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("hi", {32'd0, m.HI}, {32'd0, e.hi});
        check("lo", {32'd0, m.LO}, {32'd0, e.lo});
        check("div_by_zero", {63'd0, m.Div_By_Zero}, {63'd0, e.dbz});
      end
    end
  end

  task automatic drive_start(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input bit immediate);
    if (!immediate) begin
      @(posedge Clk);
      #1;
    end
    m.Start = 1'b1;
    m.Op    = op;
    m.Src_A = a;
    m.Src_B = b;
    @(posedge Clk);
    #1;
    m.Start = 1'b0;
    m.Op    = ~op;
    m.Src_A = $urandom;
    m.Src_B = $urandom;
  endtask

  task automatic run_op(input string name, input logic op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_hi,
                        input logic [WIDTH-1:0] exp_lo, input logic exp_dbz,
                        input bit immediate, input int glitch_cycle);
    int n;
    int busy_cnt;
    int exp_lat;
    int exp_busy;
    exp_t e;
    e.hi  = exp_hi;
    e.lo  = exp_lo;
    e.dbz = exp_dbz;
    sb_q.push_back(e);
    exp_lat  = exp_dbz ? 1 : WIDTH + 1;
    exp_busy = exp_dbz ? 0 : WIDTH;
    drive_start(op, a, b, immediate);
    n = 1;
    busy_cnt = 0;
    while ((m.Done !== 1'b1) && (n < 60)) begin
      if (m.Busy === 1'b1) busy_cnt++;
      if ((glitch_cycle != 0) && (n == glitch_cycle)) begin
        m.Start = 1'b1;
        m.Op    = 1'b1;
        m.Src_A = 32'd9;
        m.Src_B = 32'd3;
      end else begin
        m.Start = 1'b0;
      end
      @(posedge Clk);
      #1;
      n++;
    end
    m.Start = 1'b0;
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_before;
    m.Start = 1'b0;
    m.Op    = 1'b0;
    m.Src_A = '0;
    m.Src_B = '0;
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_busy", {63'd0, m.Busy}, 64'd0);
    check("rst_done", {63'd0, m.Done}, 64'd0);
    check("rst_dbz", {63'd0, m.Div_By_Zero}, 64'd0);
    check("rst_hilo", {m.HI, m.LO}, 64'd0);
    check("rst_alu_ctl", {60'd0, m.ALU_A_invert, m.ALU_B_negate, m.ALU_Operation}, 64'd0);
    Reset_n = 1'b1;

    run_op("mul_7x6", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b0, 0);
    run_op("mul_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 0);
    run_op("mul_2p16", 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 0);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, 0);
    run_op("div_max_1", 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 0);
    run_op("div_msb", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1'b0, 0);
    run_op("div_1000_10", 1'b1, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, 1'b0, 0);

    run_op("div_by_zero", 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
    @(posedge Clk);
    #1;
    check("dbz_hold_flag", {63'd0, m.Div_By_Zero}, 64'd1);
    check("dbz_hold_hilo", {m.HI, m.LO}, {32'd5, 32'hFFFFFFFF});
    check("dbz_idle_done", {63'd0, m.Done}, 64'd0);
    run_op("mul_after_dbz", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b0, 0);

    run_op("mul_ignore_start", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b0, 10);

    // Start held in the DONE cycle of the previous op; accepted with no bubble
    run_op("b2b_first", 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 0);
    run_op("b2b_second", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1, 0);

    // Reset in cycle 15 of a DIVU aborts it: no result expected
    drive_start(1'b1, 32'd1000, 32'd3, 1'b0);
    repeat (14) begin
      @(posedge Clk);
      #1;
    end
    check("abort_busy_pre", {63'd0, m.Busy}, 64'd1);
    seen_before = done_seen;
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    check("abort_busy", {63'd0, m.Busy}, 64'd0);
    check("abort_done", {63'd0, m.Done}, 64'd0);
    check("abort_hilo", {m.HI, m.LO}, 64'd0);
    repeat (40) @(posedge Clk);
    #1;
    check("abort_no_done", 64'(done_seen - seen_before), 64'd0);

    run_op("mul_after_abort", 1'b0, 32'd12, 32'd11, 32'd0, 32'd132, 1'b0, 1'b0, 0);
    repeat (2) @(posedge Clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
